ft_run_monitor: RTL and testbench

Hardware run controller and completion monitor for the fault-tolerant zeroriscy SoC. It is the inverse of the stimulus/monitor role.
- It drives the core's reset and fetch enable.
- It acts as a read-only OBI data-port initiator, polling the memory-mapped completion flag written by the running program.
- On a non-zero flag it reads the result word and compares it against an expected value.
- It reports pass, fail or timeout to the system top.

---
 rtl/ft_run_pkg.sv | 8 +
 rtl/ft_obi_read.sv | 35 +++
 rtl/ft_run_monitor.sv | 106 ++++++++++
 tb/tb_ft_run_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ft_run_pkg.sv
// ft_run_pkg: shared state encoding and default address map for the run monitor.
package ft_run_pkg;
  typedef enum logic [2:0] {
    IDLE, CORE_RST, RUN, FLAG_REQ, FLAG_WAIT, RES_REQ, RES_WAIT, DONE
  } state_t;
  localparam logic [31:0] DEF_FLAG_ADDR   = 32'h0000_1000;
  localparam logic [31:0] DEF_RESULT_ADDR = 32'h0000_1004;
endpackage

// File: rtl/ft_obi_read.sv
// ft_obi_read: single-outstanding OBI read initiator; abort drops only a not-yet-granted request.
module ft_obi_read (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  input  logic [31:0] addr,
  output logic        req,
  output logic [31:0] req_addr,
  output logic        busy,
  input  logic        gnt,
  input  logic        rvalid,
  input  logic [31:0] rdata_in,
  output logic        rdata_valid,
  output logic [31:0] rdata
);
  logic wait_rsp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req      <= 1'b0;
      wait_rsp <= 1'b0;
      req_addr <= '0;
    end else if (req) begin
      req      <= !gnt && !abort;
      wait_rsp <= gnt;
    end else if (wait_rsp) begin
      wait_rsp <= !rvalid;
    end else if (go) begin
      req      <= 1'b1;
      req_addr <= addr;
    end
  assign busy        = req | wait_rsp;
  assign rdata_valid = wait_rsp & rvalid;
  assign rdata       = rdata_in;
endmodule

// File: rtl/ft_run_monitor.sv
// ft_run_monitor: drives core reset/fetch enable, polls the completion flag over OBI and
// reports pass, fail or timeout against a captured expected result.
module ft_run_monitor
  import ft_run_pkg::*;
#(
  parameter logic [31:0] FLAG_ADDR      = DEF_FLAG_ADDR,
  parameter logic [31:0] RESULT_ADDR    = DEF_RESULT_ADDR,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned POLL_INTERVAL  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] expected_i,
  output logic        core_rst_no,
  output logic        core_fetch_en_o,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [31:0] result_o,
  output logic [31:0] cycles_o
);
  state_t      state, state_next;
  logic [31:0] wait_cnt, run_cnt, expected, rd_addr, rdata;
  logic        go, abort, rd_valid, rd_busy, tmo, late, flag_hit, accept;

  ft_obi_read u_obi (
    .clk(clk_i), .rst_n(rst_ni), .go(go), .abort(abort), .addr(rd_addr),
    .req(data_req_o), .req_addr(data_addr_o), .busy(rd_busy),
    .gnt(data_gnt_i), .rvalid(data_rvalid_i), .rdata_in(data_rdata_i),
    .rdata_valid(rd_valid), .rdata(rdata)
  );

  // A non-zero flag landing exactly on the timeout cycle still wins; one arriving later is discarded.
  assign tmo      = run_cnt >= TIMEOUT_CYCLES;
  assign late     = run_cnt > TIMEOUT_CYCLES;
  assign accept   = start_i && (state == IDLE || state == DONE);
  assign flag_hit = state == FLAG_WAIT && rd_valid && rdata != '0 && !late;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start_i ? CORE_RST : state;
      CORE_RST:   state_next = wait_cnt == RST_CYCLES - 1 ? RUN : CORE_RST;
      RUN:        state_next = tmo ? DONE : wait_cnt == POLL_INTERVAL - 1 ? FLAG_REQ : RUN;
      FLAG_REQ:   state_next = tmo ? DONE : FLAG_WAIT;
      FLAG_WAIT:
        if (flag_hit) state_next = RES_REQ;
        else if (rd_valid) state_next = tmo ? DONE : RUN;
        else if (tmo && data_req_o && !data_gnt_i) state_next = DONE;
      RES_REQ:    state_next = RES_WAIT;
      RES_WAIT:   state_next = rd_valid ? DONE : RES_WAIT;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    go              = !rd_busy && ((state == FLAG_REQ && !tmo) || state == RES_REQ);
    abort           = state == FLAG_WAIT && tmo;
    rd_addr         = state == RES_REQ ? RESULT_ADDR : FLAG_ADDR;
    core_rst_no     = !(state inside {IDLE, CORE_RST});
    core_fetch_en_o = state inside {RUN, FLAG_REQ, FLAG_WAIT, RES_REQ, RES_WAIT};
    busy_o          = !(state inside {IDLE, DONE});
    done_o          = state == DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wait_cnt  <= '0;
      run_cnt   <= '0;
      expected  <= '0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
      result_o  <= '0;
      cycles_o  <= '0;
    end else begin
      wait_cnt <= state_next != state ? '0 : wait_cnt + 32'd1;
      if (accept) begin
        expected  <= expected_i;
        run_cnt   <= '0;
        pass_o    <= 1'b0;
        timeout_o <= 1'b0;
        result_o  <= '0;
        cycles_o  <= '0;
      end else begin
        if (core_fetch_en_o && run_cnt != '1) run_cnt <= run_cnt + 32'd1;
        if (flag_hit) cycles_o <= run_cnt;
        if (state == RES_WAIT && rd_valid) begin
          result_o <= rdata;
          pass_o   <= rdata == expected;
        end
        if (state_next == DONE && state inside {RUN, FLAG_REQ, FLAG_WAIT}) timeout_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ft_run_monitor.sv
// tb_ft_run_monitor: randomized OBI memory responder plus scoreboard of expected run outcomes.
module tb_ft_run_monitor;
  localparam int R = 4, P = 8, T = 100;
  localparam logic [31:0] FA = 32'h0000_1000, RA = 32'h0000_1004;

  logic        clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0] expected_i = '0, data_rdata_i = '0;
  logic        core_rst_no, core_fetch_en_o, data_req_o, busy_o, done_o, pass_o, timeout_o;
  logic [31:0] data_addr_o, result_o, cycles_o;

  typedef struct {
    bit          tmo;
    bit          pass;
    logic [31:0] result;
    logic [31:0] cycles;
    int          start_e;
  } rec_t;
  rec_t sb[$];

  int          compared = 0, mismatched = 0, cyc = 0;
  int          nz, gdel, lat, fidx;
  bit          tmo_run, auto_resp = 1'b1;
  logic [31:0] flagval, resval;

  ft_run_monitor dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .expected_i(expected_i),
    .core_rst_no(core_rst_no), .core_fetch_en_o(core_fetch_en_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .result_o(result_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_core_rst_no"}, 32'(core_rst_no), 0);
    chk({tag, "_fetch_en"}, 32'(core_fetch_en_o), 0);
    chk({tag, "_req"}, 32'(data_req_o), 0);
    chk({tag, "_addr"}, data_addr_o, 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_pass"}, 32'(pass_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_cycles"}, cycles_o, 0);
  endtask

  // Memory-side model: the flag reads zero nz times, then flagval; cycles counted from core release.
  initial begin
    logic [31:0] a, d;
    int c;
    forever begin
      @(negedge clk);
      if (auto_resp && rst_ni && data_req_o) begin
        a = data_addr_o;
        for (int k = 0; k < gdel; k++) begin
          @(negedge clk);
          chk("req_stall", 32'(data_req_o), 1);
          chk("addr_stall", data_addr_o, a);
        end
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("req_drop_after_gnt", 32'(data_req_o), 0);
        repeat (lat - 1) @(negedge clk);
        d = 0;
        if (a == FA) begin
          d = (tmo_run || fidx < nz) ? 32'd0 : flagval;
          fidx++;
          if (d != 0 && sb.size() > 0) begin
            c = cyc - sb[sb.size()-1].start_e - R;
            if (c <= T) sb[sb.size()-1].cycles = c;
            else begin
              sb[sb.size()-1].tmo = 1'b1;
              sb[sb.size()-1].pass = 1'b0;
              sb[sb.size()-1].result = 0;
              sb[sb.size()-1].cycles = 0;
            end
          end
        end else if (a == RA) d = resval;
        else chk("read_addr", a, FA);
        data_rvalid_i = 1'b1;
        data_rdata_i  = d;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = $urandom;
      end
    end
  end

  initial begin
    rec_t r;
    bit dd = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o && !dd) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          r = sb.pop_front();
          chk("pass", 32'(pass_o), 32'(r.pass));
          chk("timeout", 32'(timeout_o), 32'(r.tmo));
          chk("result", result_o, r.result);
          chk("cycles", cycles_o, r.cycles);
          chk("done_fetch_en", 32'(core_fetch_en_o), 0);
          chk("done_core_rst_no", 32'(core_rst_no), 1);
          chk("done_busy", 32'(busy_o), 0);
          chk("done_req", 32'(data_req_o), 0);
          if (r.tmo)
            chk("timeout_latency_ok",
                32'((cyc - (r.start_e + R + T)) >= 1 && (cyc - (r.start_e + R + T)) <= P + 8), 1);
        end
      end
      dd = done_o;
    end
  end

  task automatic run(input logic [31:0] ex, res, fv, input int n, gd, lt, input bit to);
    rec_t r;
    int s;
    expected_i = ex; resval = res; flagval = fv; nz = n; gdel = gd; lat = lt; tmo_run = to; fidx = 0;
    @(negedge clk);
    start_i = 1'b1;
    s = cyc + 1;
    r.tmo = to; r.pass = !to && res == ex; r.result = to ? 32'd0 : res; r.cycles = 0; r.start_e = s;
    sb.push_back(r);
    @(negedge clk);
    start_i = 1'b0;
    expected_i = $urandom;
    chk("start_done_clr", 32'(done_o), 0);
    chk("start_pass_clr", 32'(pass_o), 0);
    chk("start_timeout_clr", 32'(timeout_o), 0);
    chk("start_result_clr", result_o, 0);
    chk("start_cycles_clr", cycles_o, 0);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_core_rst_low", 32'(core_rst_no), 0);
    repeat (R - 1) begin
      @(negedge clk);
      chk("core_rst_low", 32'(core_rst_no), 0);
      chk("core_fetch_low", 32'(core_fetch_en_o), 0);
    end
    @(negedge clk);
    chk("core_rst_release", 32'(core_rst_no), 1);
    chk("core_fetch_on", 32'(core_fetch_en_o), 1);
    for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL run_never_done: %0d records pending, done_o=%0b", sb.size(), done_o);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ex, res;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_ni = 1'b1;
    run(32'd55, 32'd55, 32'd1, 2, 5, 1, 1'b0);
    run(32'd55, 32'd54, 32'd1, 0, 0, 2, 1'b0);
    run(32'hdead_beef, 32'd0, 32'd1, 0, 0, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ex  = $urandom;
      res = $urandom_range(0, 1) ? ex : ex ^ (32'd1 << $urandom_range(0, 31));
      if (i % 4 == 3) run(ex, res, $urandom | 32'd1, 0, 0, $urandom_range(1, 3), 1'b1);
      else run(ex, res, $urandom | 32'd1, $urandom_range(0, 2), $urandom_range(0, 4),
               $urandom_range(1, 3), 1'b0);
    end
    auto_resp = 1'b0;
    expected_i = 32'd7;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 60 && !data_req_o; i++) @(negedge clk);
    chk("midrst_req_seen", 32'(data_req_o), 1);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'd1;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_req", 32'(data_req_o), 0);
      chk("after_rst_busy", 32'(busy_o), 0);
      chk("after_rst_done", 32'(done_o), 0);
      chk("after_rst_core_rst_no", 32'(core_rst_no), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
